spi_master: RTL and testbench

Mode-0 SPI initiator that drives the `sck`/`ss`/`mosi` pins of on-board SPI peripherals and samples their `miso` replies. A single request carries 1 to 16 bits. The received word is returned with a one-cycle response pulse. The block sits between a bus-side register wrapper, which drives `req_*` and consumes `rsp_*`, and the SPI pins of the peripheral tree.

---
 rtl/spi_master.sv | 134 +++++++++++++
 tb/tb_spi_master.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator, 1..16 bits per request, MSB first.
// Ports: clock/reset (async, active-high); req_valid/req_ready/req_len/req_ss/req_data
// request handshake; rsp_valid/rsp_data one-cycle completion pulse with received word;
// busy = ~req_ready; sck/ss/mosi/miso SPI pins (sck idles low, ss active-low, mosi idles 1).
// Define SPI_MASTER_TRACE_EN to print sampled bits and completions and to make an
// illegal state fatal; otherwise an illegal state falls back to IDLE silently.
module spi_master #(
    parameter int DIV  = 2,
    parameter int SS_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_len,
    input  logic [SS_W-1:0] req_ss,
    input  logic [15:0]     req_data,
    output logic            rsp_valid,
    output logic [15:0]     rsp_data,
    output logic            busy,
    output logic            sck,
    output logic [SS_W-1:0] ss,
    output logic            mosi,
    input  logic            miso
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [4:0]     bits;
    logic [14:0]    tx;
    logic [15:0]    rx;
    logic [4:0]     eff_len;
    logic [15:0]    tx_init;

    // Lengths of 0 or above 16 run as full 16-bit transfers.
    assign eff_len = (req_len == 5'd0 || req_len > 5'd16) ? 5'd16 : req_len;
    // Left-align the transmit word so the first bit always sits at bit 15.
    assign tx_init = req_data << (5'd16 - eff_len);
    assign busy    = ~req_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bits      <= '0;
            tx        <= '0;
            rx        <= '0;
            sck       <= 1'b0;
            ss        <= '1;
            mosi      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            req_ready <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= SETUP;
                        cnt       <= '0;
                        bits      <= eff_len;
                        tx        <= tx_init[14:0];
                        mosi      <= tx_init[15];
                        rx        <= '0;
                        ss        <= ~req_ss;
                        req_ready <= 1'b0;
                    end
                end
                SETUP, LOW: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        sck   <= 1'b1;
                        rx    <= {rx[14:0], miso};
                        state <= HIGH;
`ifdef SPI_MASTER_TRACE_EN
                        $write("spi rx bit %0d: %0b\n", bits - 5'd1, miso);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == LAST) begin
                        cnt  <= '0;
                        sck  <= 1'b0;
                        bits <= bits - 5'd1;
                        if (bits != 5'd1) begin
                            mosi  <= tx[14];
                            tx    <= {tx[13:0], 1'b0};
                            state <= LOW;
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        ss        <= '1;
                        mosi      <= 1'b1;
                        rsp_data  <= rx;
                        rsp_valid <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
`ifdef SPI_MASTER_TRACE_EN
                        $write("spi done %04h\n", rx);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
`ifdef SPI_MASTER_TRACE_EN
                    $fatal(1, "spi_master: illegal state %0d", state);
`else
                    state     <= IDLE;
                    cnt       <= '0;
                    bits      <= '0;
                    sck       <= 1'b0;
                    ss        <= '1;
                    mosi      <= 1'b1;
                    req_ready <= 1'b1;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized self-checking bench for spi_master with a behavioural slave.
module tb_spi_master;
    localparam int DIV = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_len = '0;
    logic [7:0]  req_ss = '0;
    logic [15:0] req_data = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        busy, sck, mosi, miso;
    logic [7:0]  ss;
    logic        miso_r = 1'b0;
    int          miso_mode = 0;
    int          errors = 0;
    int          checks = 0;

    // Mode 1 ties miso straight to mosi (loopback); otherwise the slave model drives miso_r.
    assign miso = (miso_mode == 1) ? mosi : miso_r;

    spi_master #(.DIV(DIV), .SS_W(8)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_len(req_len), .req_ss(req_ss), .req_data(req_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .busy(busy), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sck"}, 32'(sck), 32'd0);
        check({tag, "_ss"}, 32'(ss), 32'hFF);
        check({tag, "_mosi"}, 32'(mosi), 32'd1);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
    endtask

    // Issues one request at a negedge and follows it to completion, checking pin timing,
    // mosi bit order and the received word. chain keeps req_valid high for a back-to-back
    // follow-up; abort_at > 0 asserts reset right after that many sck rises.
    task automatic xfer(input logic [4:0] len, input logic [15:0] data, input logic [7:0] sel,
                        input int mode, input logic [15:0] reply, input bit chain, input int abort_at);
        int L, n, rises, falls, w, pulses;
        logic psck;
        logic [7:0] nsel;
        logic [15:0] mask, exp_rx;
        bit done;
        L = (len == 0 || len > 16) ? 16 : int'(len);
        mask = 16'((32'h1 << L) - 1);
        exp_rx = (mode == 0) ? (reply & mask) : (mode == 1) ? (data & mask) : mask;
        nsel = ~sel;
        req_len = len; req_data = data; req_ss = sel; miso_mode = mode; req_valid = 1'b1;
        miso_r = (mode == 2) ? 1'b1 : reply[L-1];
        w = 0;
        do begin @(negedge clock); w++; end while (!busy && w < 20);
        check("accept_wait", 32'(w), 32'd1);
        if (!chain) req_valid = 1'b0;
        n = 0; rises = 0; falls = 0; psck = 1'b0; done = 1'b0;
        while (!done && n < 200) begin
            if (!rsp_valid) begin
                check("ss_active", 32'(ss), 32'(nsel));
                check("ready_low", 32'(req_ready), 32'd0);
            end
            @(negedge clock); n++;
            if (sck && !psck) begin
                check("rise_time", 32'(n), 32'((2 * rises + 1) * DIV));
                check("mosi_bit", 32'(mosi), 32'(data[L-1-rises]));
                rises++;
                if (rises == abort_at) begin
                    @(posedge clock); #2 reset = 1'b1;
                    #1 check_idle("abort");
                    check("abort_rsp_data", 32'(rsp_data), 32'd0);
                    @(negedge clock); reset = 1'b0;
                    pulses = 0;
                    for (int i = 0; i < 60; i++) begin
                        @(negedge clock);
                        if (rsp_valid) pulses++;
                    end
                    check("abort_no_rsp", 32'(pulses), 32'd0);
                    check_idle("after_abort");
                    return;
                end
            end
            if (!sck && psck) begin
                falls++;
                if (mode == 0 && falls < L) miso_r = reply[L-1-falls];
            end
            psck = sck;
            if (rsp_valid) done = 1'b1;
        end
        check("done_time", 32'(n), 32'((2 * L + 1) * DIV));
        check("rise_count", 32'(rises), 32'(L));
        check("rsp_data", 32'(rsp_data), 32'(exp_rx));
        check("done_ready", 32'(req_ready), 32'd1);
        check("done_ss", 32'(ss), 32'hFF);
        check("done_mosi", 32'(mosi), 32'd1);
        check("done_sck", 32'(sck), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_idle("post_reset");
        @(posedge clock); #2 reset = 1'b1;
        #1 check_idle("reset_async");
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
        xfer(5'd8, 16'h00A5, 8'h01, 0, 16'h003C, 1'b0, 0);
        xfer(5'd16, 16'hBEEF, 8'h02, 1, 16'h0000, 1'b0, 0);
        xfer(5'd0, 16'h1234, 8'h04, 2, 16'h0000, 1'b0, 0);
        xfer(5'd1, 16'h0001, 8'h80, 0, 16'h0001, 1'b0, 0);
        xfer(5'd8, 16'h005A, 8'h08, 0, 16'h0099, 1'b1, 0);
        xfer(5'd5, 16'h0013, 8'h40, 0, 16'h000A, 1'b0, 0);
        xfer(5'd8, 16'h0077, 8'h10, 0, 16'h0012, 1'b0, 3);
        xfer(5'd8, 16'h00C3, 8'h20, 0, 16'h0081, 1'b0, 0);
        for (int i = 0; i < 25; i++) begin
            xfer(5'($urandom_range(0, 31)), 16'($urandom), 8'(1 << $urandom_range(0, 7)),
                 int'($urandom_range(0, 2)), 16'($urandom),
                 (i == 24) ? 1'b0 : 1'($urandom_range(0, 1)), 0);
        end
        repeat (3) @(negedge clock);
        check_idle("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
